bandai_eeprom_ctrl: RTL
=======================

Name: bandai_eeprom_ctrl

Overview:
- Cartridge-side serial EEPROM controller that sits beside the bank-register mapper on the same cartridge bus.
- Decodes its own small register window and turns host register writes into Microwire (93Cx6-style, x16 organisation) frames on CS/SK/DO.
- Captures DI read data back into the register file and reports status to the host.
- Handles the write/erase busy poll in hardware, so the host only polls one status register.

Parameters:
- CLK_DIV, 4: CLK cycles per SK half-period, minimum 1.
- ADDR_BITS, 6: EEPROM word-address width; 6 selects a 93C46 x16.
- BUSY_TIMEOUT, 16'hFFFF: maximum SK periods to wait for ready after a write or erase.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- BUS_SEL  in  1  register window selected; qualifies BUS_WR and BUS_RD.
- BUS_WR  in  1  one-cycle write strobe.
- BUS_RD  in  1  read enable; RDATA is combinational from ADDR.
- ADDR  in  3  register offset.
- WDATA  in  8  write data.
- RDATA  out  8  read data.
- EE_CS  out  1  EEPROM chip select, active high.
- EE_SK  out  1  EEPROM serial clock.
- EE_DO  out  1  serial data to the EEPROM DI pin.
- EE_DI  in  1  serial data from the EEPROM DO pin; also the ready/busy indicator.
- BUSY  out  1  operation in progress.

Behaviour:
- Reset is asynchronous and active-high.
- Reset values:
  - all registers 0
  - EE_CS=0, EE_SK=0, EE_DO=0, BUSY=0
  - status READY=1
  - FSM in IDLE
- Asserting RST mid-frame aborts the frame immediately and restores all reset values.
- Register map:
  - 0: DATA_LO (r/w)
  - 1: DATA_HI (r/w)
  - 2: ADDR_LO (r/w)
  - 3: ADDR_HI (r/w; only bits above bit 7 of ADDR_BITS are used)
  - 4: CMD (write) / STATUS (read)
  - offsets 5-7 read 0; writes to them are ignored.
- Writes to offsets 0-3 are ignored while BUSY=1.
- CMD is one-hot:
  - bit0 READ
  - bit1 WRITE
  - bit2 ERASE
  - bit3 EWEN
  - bit4 EWDS
- A CMD write that has zero or more than one bit set, or arrives while BUSY=1:
  - starts no operation
  - sets ERR
- A legal CMD write clears DONE and ERR, sets BUSY=1 and READY=0 on the next CLK, and leaves IDLE.
- STATUS bits:
  - bit0 DONE
  - bit1 READY (equals ~BUSY)
  - bit2 ERR
  - bit3 TIMEOUT
  - bit7 BUSY
  - other bits 0
- DONE, ERR and TIMEOUT are sticky until the next legal CMD write.
- Frame layout, MSB first: start bit 1, then a 2-bit opcode, then an ADDR_BITS field.
  - READ: opcode 10, address field = address.
  - WRITE: opcode 01, address field = address, followed by {DATA_HI,DATA_LO}.
  - ERASE: opcode 11, address field = address.
  - EWEN: opcode 00, address field = 11 followed by zeros.
  - EWDS: opcode 00, address field = 00 followed by zeros.
- Bit timing:
  - Each bit lasts 2*CLK_DIV CLK cycles.
  - EE_DO changes only while EE_SK=0.
  - EE_SK rises after CLK_DIV cycles and falls after another CLK_DIV.
  - EE_DI is sampled on the CLK in which EE_SK rises.
- FSM states: IDLE, CS_SETUP, SHIFT_OUT, SHIFT_IN, CS_GAP, POLL, FINISH.
  - IDLE -> CS_SETUP on a legal CMD.
  - CS_SETUP: EE_CS=1 for CLK_DIV cycles, EE_SK=0.
  - SHIFT_OUT: the frame bit counter counts down.
  - SHIFT_OUT -> SHIFT_IN (READ only): shift 17 bits, discarding the leading dummy 0, and load {DATA_HI,DATA_LO} MSB first.
  - SHIFT_OUT -> CS_GAP (WRITE/ERASE): EE_CS=0 for CLK_DIV cycles.
  - CS_GAP -> POLL: EE_CS=1; EE_DI is sampled once per 2*CLK_DIV cycles.
    - DI=1 -> FINISH.
    - After BUSY_TIMEOUT samples -> FINISH with ERR=1 and TIMEOUT=1.
  - SHIFT_OUT (EWEN/EWDS) and SHIFT_IN -> FINISH.
  - FINISH: EE_CS=0, EE_SK=0, EE_DO=0, DONE=1, BUSY=0, then -> IDLE.
- Total busy time for READ with ADDR_BITS=6, CLK_DIV=4 is 4 + (9+17)*8 + 1 = 213 CLK cycles from the CMD write to BUSY=0.
- DATA_LO/HI:
  - are updated by READ only, in the FINISH cycle.
  - Host writes to them landing in the same cycle as the update lose.
- Address bits above ADDR_BITS are ignored.

Test Plan:
- Reset, then read offset 4 -> RDATA=8'h02; EE_CS=0, EE_SK=0, BUSY=0.
- EWEN, CLK_DIV=4 -> EE_DO stream 1,00,110000 (9 bits); EE_SK 9 pulses of 8 CLK; STATUS=8'h03 at end.
- ADDR_LO=8'h05, READ, model drives 0 then 16'hBEEF -> DATA_HI=8'hBE, DATA_LO=8'hEF, DONE=1; BUSY for 213 CLK.
- DATA=16'h1234, ADDR_LO=8'h3F, WRITE, model holds DI=0 for 20 polls then 1 -> stream 1,01,111111,0001001000110100; CS low gap of 4 CLK; DONE=1, ERR=0.
- ERASE, model never releases DI, BUSY_TIMEOUT=16 -> after 16 polls STATUS=8'h0F.
- CMD=8'h03 -> ERR=1, no EE_CS activity.
- READ started, second CMD mid-frame -> ERR=1, frame completes.
- RST mid-READ -> all reset values immediately.

Source files
------------

// File: rtl/bandai_eeprom_ctrl.sv
// Cartridge-side Microwire (93Cx6, x16) EEPROM controller.
// Host register writes become CS/SK/DO frames; DI read data lands in DATA_HI/LO,
// and the post-write/erase ready poll runs in hardware.
module bandai_eeprom_ctrl #(
  parameter int          CLK_DIV      = 4,
  parameter int          ADDR_BITS    = 6,
  parameter logic [15:0] BUSY_TIMEOUT = 16'hFFFF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BUS_SEL,
  input  logic       BUS_WR,
  input  logic       BUS_RD,
  input  logic [2:0] ADDR,
  input  logic [7:0] WDATA,
  output logic [7:0] RDATA,
  output logic       EE_CS,
  output logic       EE_SK,
  output logic       EE_DO,
  input  logic       EE_DI,
  output logic       BUSY
);
  localparam int FW = 3 + ADDR_BITS + 16;        // longest frame (WRITE)
  localparam int BW = $clog2(FW + 1);
  localparam int CW = $clog2(2 * CLK_DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT_OUT, SHIFT_IN, CS_GAP, POLL, FINISH} state_t;

  state_t        state_q;
  logic [7:0]    data_lo_q, data_hi_q, addr_lo_q, addr_hi_q;
  logic [2:0]    op_q;                           // {ERASE, WRITE, READ}; zero = EWEN/EWDS
  logic          done_q, err_q, to_q, busy_q;
  logic          cs_q, sk_q, do_q, rdy_q;
  logic [CW-1:0] div_q;
  logic [BW-1:0] bits_q;
  logic [FW-1:0] sr_q;
  logic [15:0]   rx_q, poll_q;

  logic                 cmd_wr, cmd_ok, reg_wr, half_end, bit_end;
  logic [1:0]           opc;
  logic [ADDR_BITS-1:0] afield;
  logic [FW-1:0]        frame_d;
  logic [BW-1:0]        nbits_d;
  logic [7:0]           status;

  assign cmd_wr   = BUS_SEL && BUS_WR && (ADDR == 3'd4);
  assign cmd_ok   = $onehot(WDATA) && (WDATA[7:5] == 3'b000);
  assign reg_wr   = BUS_SEL && BUS_WR && !ADDR[2] && !busy_q;
  assign half_end = (div_q == HALF);
  assign bit_end  = (div_q == LAST);
  assign status   = {busy_q, 3'b000, to_q, err_q, ~busy_q, done_q};
  assign EE_CS    = cs_q;
  assign EE_SK    = sk_q;
  assign EE_DO    = do_q;
  assign BUSY     = busy_q;

  // Build the outgoing frame, left-aligned, from the command being written.
  always_comb begin
    opc    = {WDATA[0] | WDATA[2], WDATA[1] | WDATA[2]};
    afield = ADDR_BITS'({addr_hi_q, addr_lo_q});
    if (WDATA[3]) begin
      afield = '0;
      afield[ADDR_BITS-1 -: 2] = 2'b11;
    end else if (WDATA[4]) begin
      afield = '0;
    end
    frame_d = '0;
    frame_d[FW-1 -: 3]         = {1'b1, opc};
    frame_d[FW-4 -: ADDR_BITS] = afield;
    if (WDATA[1]) frame_d[15:0] = {data_hi_q, data_lo_q};
    nbits_d = WDATA[1] ? BW'(FW) : BW'(3 + ADDR_BITS);
  end

  // Host read mux.
  always_comb begin
    RDATA = 8'h00;
    if (BUS_SEL && BUS_RD) begin
      case (ADDR)
        3'd0:    RDATA = data_lo_q;
        3'd1:    RDATA = data_hi_q;
        3'd2:    RDATA = addr_lo_q;
        3'd3:    RDATA = addr_hi_q;
        3'd4:    RDATA = status;
        default: RDATA = 8'h00;
      endcase
    end
  end

  // Register file, frame sequencer and registered pin outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      data_lo_q <= '0; data_hi_q <= '0; addr_lo_q <= '0; addr_hi_q <= '0;
      op_q      <= '0;
      done_q    <= 1'b0; err_q <= 1'b0; to_q <= 1'b0; busy_q <= 1'b0;
      cs_q      <= 1'b0; sk_q  <= 1'b0; do_q <= 1'b0; rdy_q  <= 1'b0;
      div_q     <= '0; bits_q <= '0; sr_q <= '0; rx_q <= '0; poll_q <= '0;
    end else begin
      if (reg_wr) begin
        case (ADDR[1:0])
          2'd0:    data_lo_q <= WDATA;
          2'd1:    data_hi_q <= WDATA;
          2'd2:    addr_lo_q <= WDATA;
          default: addr_hi_q <= WDATA;
        endcase
      end
      if (cmd_wr && (busy_q || !cmd_ok)) err_q <= 1'b1;

      case (state_q)
        IDLE: if (cmd_wr && cmd_ok) begin
          done_q  <= 1'b0; err_q <= 1'b0; to_q <= 1'b0;
          busy_q  <= 1'b1; cs_q  <= 1'b1;
          op_q    <= WDATA[2:0];
          sr_q    <= frame_d;
          bits_q  <= nbits_d;
          div_q   <= '0;
          state_q <= CS_SETUP;
        end
        CS_SETUP: begin
          div_q <= div_q + CW'(1);
          if (half_end) begin
            div_q   <= '0;
            do_q    <= sr_q[FW-1];
            sr_q    <= sr_q << 1;
            bits_q  <= bits_q - BW'(1);
            state_q <= SHIFT_OUT;
          end
        end
        SHIFT_OUT: begin
          div_q <= div_q + CW'(1);
          if (half_end) sk_q <= 1'b1;
          if (bit_end) begin
            div_q <= '0;
            sk_q  <= 1'b0;
            if (bits_q != '0) begin
              do_q   <= sr_q[FW-1];
              sr_q   <= sr_q << 1;
              bits_q <= bits_q - BW'(1);
            end else begin
              do_q <= 1'b0;
              if (op_q[0]) begin
                bits_q  <= BW'(16);              // dummy 0 + 16 data bits
                state_q <= SHIFT_IN;
              end else begin
                cs_q    <= 1'b0;
                state_q <= (op_q[1] || op_q[2]) ? CS_GAP : FINISH;
              end
            end
          end
        end
        SHIFT_IN: begin
          div_q <= div_q + CW'(1);
          if (half_end) begin
            sk_q <= 1'b1;
            rx_q <= {rx_q[14:0], EE_DI};       // dummy bit falls off the top
          end
          if (bit_end) begin
            div_q <= '0;
            sk_q  <= 1'b0;
            if (bits_q != '0) bits_q <= bits_q - BW'(1);
            else begin
              cs_q    <= 1'b0;
              state_q <= FINISH;
            end
          end
        end
        CS_GAP: begin
          div_q <= div_q + CW'(1);
          if (half_end) begin
            div_q   <= '0;
            cs_q    <= 1'b1;
            poll_q  <= '0;
            rdy_q   <= 1'b0;
            state_q <= POLL;
          end
        end
        POLL: begin
          // one DI sample per SK period; leave only at a bit boundary so SK ends low
          div_q <= div_q + CW'(1);
          if (half_end) begin
            sk_q   <= 1'b1;
            rdy_q  <= EE_DI;
            poll_q <= poll_q + 16'd1;
          end
          if (bit_end) begin
            div_q <= '0;
            sk_q  <= 1'b0;
            if (rdy_q) begin
              cs_q    <= 1'b0;
              state_q <= FINISH;
            end else if (poll_q == BUSY_TIMEOUT) begin
              cs_q    <= 1'b0;
              err_q   <= 1'b1;
              to_q    <= 1'b1;
              state_q <= FINISH;
            end
          end
        end
        FINISH: begin
          cs_q    <= 1'b0; sk_q <= 1'b0; do_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (op_q[0]) {data_hi_q, data_lo_q} <= rx_q;  // beats any host write
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
